// File: rtl/serial_frame_rx.sv
// Hunts an LSB-first sync word, then assembles WIDTH payload bits plus an even-parity bit.
// Outputs are registered; dout_valid pulses on the parity-bit edge. din_valid=0 simply freezes all state.
module serial_frame_rx #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SYNC  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             par_err,
    output logic             locked,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       err_cnt
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_PARITY  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] window_q, window_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             par_err_q, par_err_d;
    logic             locked_q, locked_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] win_shift;
    logic             bad_par;

    assign win_shift = {din, window_q[WIDTH-1:1]};
    assign bad_par   = (^shreg_q) ^ din;

    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        par_err_d    = par_err_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    window_d = win_shift;
                    if (win_shift == SYNC) begin
                        state_d   = ST_PAYLOAD;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                    end
                end
                ST_PAYLOAD: begin
                    // Sync detection is deliberately off here; payload bits never re-arm the hunt.
                    shreg_d   = {din, shreg_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = '0;
                    end
                end
                ST_PARITY: begin
                    dout_d       = shreg_q;
                    par_err_d    = bad_par;
                    dout_valid_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    if (bad_par && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    window_d = '0;
                    state_d  = ST_HUNT;
                end
                default: begin
                    state_d  = ST_HUNT;
                    window_d = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_PAYLOAD) || (state_d == ST_PARITY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            window_q     <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            locked_q     <= 1'b0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            par_err_q    <= par_err_d;
            locked_q     <= locked_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign par_err    = par_err_q;
    assign locked     = locked_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: sync hunt, parity, stalls, reset, counter limits.
module tb_serial_frame_rx;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        par_err;
    logic        locked;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    serial_frame_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .par_err    (par_err),
        .locked     (locked),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        din = 1'b0;
        din_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        din = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int gap);
        for (int i = 0; i < 8; i++) send_bit(w[i], gap);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dout, dout_valid, par_err, locked, frame_cnt, err_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h v=%b pe=%b lk=%b fc=%h ec=%h, want all 0",
                     dout, dout_valid, par_err, locked, frame_cnt, err_cnt);
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        send_word(8'hA5, 0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL good_locked: got %b want 1", locked); end
        send_word(8'h3C, 0);
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, dout, par_err, frame_cnt, err_cnt, locked} !== {1'b1, 8'h3C, 1'b0, 16'd1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL good_frame: got v=%b dout=%h pe=%b fc=%0d ec=%0d lk=%b, want v=1 dout=3c pe=0 fc=1 ec=0 lk=0",
                     dout_valid, dout, par_err, frame_cnt, err_cnt, locked);
        end
        idle_cycle();
        checks++;
        if ({dout_valid, dout} !== {1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL good_pulse_end: got v=%b dout=%h, want v=0 dout=3c", dout_valid, dout);
        end
    endtask

    task automatic test_bad_parity();
        do_reset();
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_bit(1'b1, 0);
        checks++;
        if ({dout_valid, dout, par_err, frame_cnt, err_cnt} !== {1'b1, 8'h3C, 1'b1, 16'd1, 8'd1}) begin
            errors++;
            $display("FAIL bad_parity: got v=%b dout=%h pe=%b fc=%0d ec=%0d, want v=1 dout=3c pe=1 fc=1 ec=1",
                     dout_valid, dout, par_err, frame_cnt, err_cnt);
        end
        send_word(8'hA5, 0);
        send_word(8'h81, 0);
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, dout, par_err, frame_cnt, err_cnt} !== {1'b1, 8'h81, 1'b0, 16'd2, 8'd1}) begin
            errors++;
            $display("FAIL good_after_bad: got v=%b dout=%h pe=%b fc=%0d ec=%0d, want v=1 dout=81 pe=0 fc=2 ec=1",
                     dout_valid, dout, par_err, frame_cnt, err_cnt);
        end
    endtask

    task automatic test_stalls_noise();
        logic [4:0] noise;
        do_reset();
        noise = 5'b11011;
        for (int i = 0; i < 5; i++) send_bit(noise[i], 3);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL noise_locked: got %b want 0", locked); end
        send_word(8'hA5, 3);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL stall_locked: got %b want 1", locked); end
        send_word(8'h3C, 3);
        checks++;
        if ({dout_valid, frame_cnt, locked} !== {1'b0, 16'd0, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b fc=%0d lk=%b, want v=0 fc=0 lk=1", dout_valid, frame_cnt, locked);
        end
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, dout, par_err, frame_cnt, err_cnt} !== {1'b1, 8'h3C, 1'b0, 16'd1, 8'd0}) begin
            errors++;
            $display("FAIL stall_frame: got v=%b dout=%h pe=%b fc=%0d ec=%0d, want v=1 dout=3c pe=0 fc=1 ec=0",
                     dout_valid, dout, par_err, frame_cnt, err_cnt);
        end
        idle_cycle();
        checks++;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse_end: got %b want 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        send_word(8'hA5, 0);
        send_word(8'hA5, 0);
        checks++;
        if ({locked, dout_valid} !== 2'b10) begin
            errors++;
            $display("FAIL sync_payload_locked: got lk=%b v=%b, want lk=1 v=0", locked, dout_valid);
        end
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, dout, par_err, frame_cnt} !== {1'b1, 8'hA5, 1'b0, 16'd2}) begin
            errors++;
            $display("FAIL sync_payload: got v=%b dout=%h pe=%b fc=%0d, want v=1 dout=a5 pe=0 fc=2",
                     dout_valid, dout, par_err, frame_cnt);
        end
        send_word(8'hA5, 0);
        send_word(8'h81, 0);
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, dout, frame_cnt} !== {1'b1, 8'h81, 16'd3}) begin
            errors++;
            $display("FAIL back_to_back: got v=%b dout=%h fc=%0d, want v=1 dout=81 fc=3", dout_valid, dout, frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] pay;
        int pulses;
        pay = 8'h3C;
        pulses = 0;
        send_word(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_bit(pay[i], 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dout, dout_valid, par_err, locked, frame_cnt, err_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: got dout=%h v=%b pe=%b lk=%b fc=%h ec=%h, want all 0",
                     dout, dout_valid, par_err, locked, frame_cnt, err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 4; i < 8; i++) begin
            send_bit(pay[i], 0);
            if (dout_valid) pulses++;
        end
        send_bit(1'b0, 0);
        if (dout_valid) pulses++;
        checks++;
        if ({pulses[7:0], frame_cnt, locked} !== {8'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL partial_discard: got pulses=%0d fc=%0d lk=%b, want 0 0 0", pulses, frame_cnt, locked);
        end
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, dout, frame_cnt} !== {1'b1, 8'h3C, 16'd1}) begin
            errors++;
            $display("FAIL after_reset_frame: got v=%b dout=%h fc=%0d, want v=1 dout=3c fc=1", dout_valid, dout, frame_cnt);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            send_word(8'hA5, 0);
            send_word(8'h00, 0);
            send_bit(1'b1, 0);
            if (n == 254 || n == 255 || n == 256) begin
                checks++;
                if ({par_err, err_cnt} !== {1'b1, (n >= 255) ? 8'hFF : 8'hFE}) begin
                    errors++;
                    $display("FAIL err_saturate_%0d: got pe=%b ec=%h, want pe=1 ec=%h",
                             n, par_err, err_cnt, (n >= 255) ? 8'hFF : 8'hFE);
                end
            end
        end
        checks++;
        if (frame_cnt !== 16'd256) begin
            errors++;
            $display("FAIL frame_cnt_256: got %0d want 256", frame_cnt);
        end
    endtask

    task automatic test_frame_wrap();
        #2;
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        #1;
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_bit(1'b0, 0);
        checks++;
        if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL frame_cnt_max: got %h want ffff", frame_cnt); end
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_bit(1'b0, 0);
        checks++;
        if ({dout_valid, frame_cnt, err_cnt} !== {1'b1, 16'h0000, 8'hFF}) begin
            errors++;
            $display("FAIL frame_cnt_wrap: got v=%b fc=%h ec=%h, want v=1 fc=0000 ec=ff", dout_valid, frame_cnt, err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_stalls_noise();
        test_back_to_back();
        test_reset_mid_frame();
        test_err_saturate();
        test_frame_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver that sits directly downstream of the serial shift-register stage and consumes its one-bit `out` stream. It hunts for a fixed sync word in the LSB-first bit stream, then assembles the following WIDTH-bit payload and one even-parity bit into a parallel word. Each received frame is presented with a single-cycle valid strobe, a parity-error flag and running frame/error counters.

## Interface
- `WIDTH`: default 8; payload and sync-word width in bits (2..32).
- `SYNC`: default 8'hA5; sync pattern, WIDTH bits, compared LSB-first.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 1: serial data bit, LSB first; driven by the upstream shift-register `out`.
- `din_valid` input 1: qualifies `din`. A bit is consumed only on an edge where this is 1.
- `dout` output WIDTH: last assembled payload. It holds until the next frame completes.
- `dout_valid` output 1: one-cycle pulse when `dout`/`par_err` update.
- `par_err` output 1: parity result of the frame in `dout`; 1 means an odd total count of ones. It holds with `dout`.
- `locked` output 1: 1 while in PAYLOAD or PARITY state.
- `frame_cnt` output 16: frames completed, wraps 16'hFFFF -> 0.
- `err_cnt` output 8: frames with `par_err`=1, saturates at 8'hFF.

## Operation
- State machine: HUNT -> PAYLOAD -> PARITY -> HUNT. On reset the state is HUNT.
- HUNT:
  - On each consumed bit, `window <= {din, window[WIDTH-1:1]}`.
  - If the shifted value equals SYNC, go to PAYLOAD with `bit_cnt` = 0 and the shift register cleared.
  - Overlapping sync candidates are caught naturally by the sliding window.
- PAYLOAD:
  - On each consumed bit, `shreg <= {din, shreg[WIDTH-1:1]}` and `bit_cnt` increments.
  - When the WIDTH-th bit is consumed (`bit_cnt` == WIDTH-1), go to PARITY.
  - Sync patterns inside the payload are not detected.
- PARITY:
  - On the consumed bit, `dout <= shreg`.
  - `par_err <= ^shreg ^ din`, i.e. even parity over payload plus parity bit.
  - Pulse `dout_valid`, increment `frame_cnt`, increment `err_cnt` if the parity is bad and the count is not 8'hFF.
  - Clear `window` to 0 and return to HUNT.
- `din_valid`=0 on any edge: no state, counter, window or shift-register change; `dout_valid` is 0 on that edge.
- `bit_cnt` width is `$clog2(WIDTH)`. `frame_cnt` wraps modulo 2^16. `err_cnt` never wraps.
- Reset values: `dout`=0, `dout_valid`=0, `par_err`=0, `locked`=0, `frame_cnt`=0, `err_cnt`=0. Internally `window`=0, `shreg`=0, `bit_cnt`=0, state HUNT.
- Reset mid-frame: the partial frame is discarded, with no `dout_valid`, and hunting restarts from an empty window.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Sync detect: `locked` goes to 1 on the edge that consumes the last sync bit.
- Frame latency: `dout_valid` goes to 1 on the edge that consumes the parity bit and returns to 0 on the next edge. `locked` goes to 0 on that same parity edge.
- Minimum frame length is 2*WIDTH+1 consumed bits, counting from the start of the sync word. Back-to-back frames need a full new sync word.
- `dout` and `par_err` change only on the `dout_valid` edge.
- `din_valid` gaps of any length in any state stretch timing but do not alter the result.

## Test plan
- **Good frame:** after reset, feed 1,0,1,0,0,1,0,1 (A5 LSB-first), then 0,0,1,1,1,1,0,0 (3C LSB-first), then parity 0, all with `din_valid`=1.
  - `locked` rises after bit 8.
  - One-cycle `dout_valid` after bit 17, with `dout`=8'h3C, `par_err`=0, `frame_cnt`=1, `err_cnt`=0.
- **Bad parity:** same frame with parity bit 1 -> `dout`=8'h3C, `par_err`=1, `err_cnt`=1. Then a good frame of 8'h81 with parity 0 -> `par_err`=0, `err_cnt` stays 1, `frame_cnt`=2.
- **Stalls and noise:**
  - Feed 5 noise bits 1,1,0,1,1 before the sync, and insert `din_valid`=0 for 3 cycles between every bit of a 3C frame. Result must match the good-frame case.
  - A payload of 8'hA5 must still complete as a normal frame.
- **Reset mid-frame:** assert `rst` after 4 payload bits.
  - All outputs return to 0 asynchronously and no `dout_valid` is produced.
  - A following good frame yields `frame_cnt`=1.
- **Counter limits:** 256 bad-parity frames -> `err_cnt` holds 8'hFF. Force or run 65536 frames -> `frame_cnt` wraps to 0.
